// File: rtl/rx_data_sampler.sv
// rx_data_sampler: oversampling front end of the UART receiver.
// Tracks the edge position within each bit and the bit index within the
// frame, and majority-votes three samples around mid-bit into one clean
// bit per bit period.
//
// Optional build macro: RX_SYNC_EN. When defined, RX_IN passes through a
// 2-flop synchronizer (reset value 1) before sampling; counter timing is
// unchanged.
//
// Ports:
//   CLK          in   oversampling clock (prescale x baud)
//   RST          in   synchronous active-low reset
//   RX_IN        in   serial line, idle high
//   prescale     in   oversampling ratio, legal 8/16/32 (others act as 8)
//   samp_en      in   sampling/counting enable from the RX FSM
//   sampled_bit  out  majority-voted bit value
//   sample_valid out  one-cycle pulse when sampled_bit is updated
//   edge_cnt     out  edge index within the current bit, 0..P-1
//   bit_cnt      out  bit index within the frame (saturating), start bit = 0
//   bit_done     out  one-cycle pulse at the first cycle of each new bit
module rx_data_sampler #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  samp_en,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done
);

  localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);

  logic [PRESCALE_W-1:0] r_p;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_sampled_bit;
  logic                  r_sample_valid;
  logic                  r_bit_done;
  logic                  r_s0, r_s1, r_s2;

  logic                  w_rx;
  logic [PRESCALE_W-1:0] w_p_legal;
  logic [PRESCALE_W-1:0] w_h;
  logic [PRESCALE_W-1:0] w_last;
  logic                  w_maj;

`ifdef RX_SYNC_EN
  // Two-flop synchronizer on the asynchronous serial line.
  logic r_sync1, r_sync2;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx = r_sync2;
`else
  assign w_rx = RX_IN;
`endif

  // Illegal prescale values fall back to 8.
  always_comb begin
    w_p_legal = P8;
    if (prescale == P16 || prescale == P32) w_p_legal = prescale;
  end

  assign w_h    = r_p >> 1;
  assign w_last = r_p - PRESCALE_W'(1);
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);

  // Counters, sample triple and voted output.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_p            <= P8;
      r_edge_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_sampled_bit  <= 1'b1;
      r_sample_valid <= 1'b0;
      r_bit_done     <= 1'b0;
      r_s0           <= 1'b1;
      r_s1           <= 1'b1;
      r_s2           <= 1'b1;
    end else if (!samp_en) begin
      // Prescale only moves while idle so it is stable for a whole frame;
      // any partially collected triple is simply never voted.
      r_p            <= w_p_legal;
      r_edge_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_sample_valid <= 1'b0;
      r_bit_done     <= 1'b0;
    end else begin
      if (r_edge_cnt == w_last) begin
        r_edge_cnt <= '0;
        r_bit_done <= 1'b1;
        if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
        r_bit_done <= 1'b0;
      end

      if (r_edge_cnt == w_h - PRESCALE_W'(1)) r_s0 <= w_rx;
      if (r_edge_cnt == w_h)                  r_s1 <= w_rx;
      if (r_edge_cnt == w_h + PRESCALE_W'(1)) r_s2 <= w_rx;

      if (r_edge_cnt == w_h + PRESCALE_W'(2)) begin
        r_sampled_bit  <= w_maj;
        r_sample_valid <= 1'b1;
      end else begin
        r_sample_valid <= 1'b0;
      end
    end
  end

  assign sampled_bit  = r_sampled_bit;
  assign sample_valid = r_sample_valid;
  assign edge_cnt     = r_edge_cnt;
  assign bit_cnt      = r_bit_cnt;
  assign bit_done     = r_bit_done;

endmodule

// File: doc/rx_data_sampler.md
Name: rx_data_sampler

Overview:
- Oversampling front end of the UART receiver. Tracks the edge position within each bit and the bit index within the frame.
- Majority-votes three samples around mid-bit to produce one clean bit per bit period.
- Feeds sampled_bit/sample_valid to the start-glitch, parity and stop checkers and to the deserializer. Exports edge_cnt/bit_cnt to the RX FSM.
- Enabled by the RX FSM through samp_en.

Parameters:
- PRESCALE_W, 6, width of prescale input and edge_cnt.
- BIT_CNT_W, 4, width of bit_cnt.

Ports:
- CLK  input  1  oversampling clock (prescale × baud).
- RST  input  1  synchronous, active-low reset, sampled on CLK rising edge.
- RX_IN  input  1  serial line, idle high.
- prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- samp_en  input  1  sampling/counting enable from RX FSM.
- sampled_bit  output  1  majority-voted bit value, registered.
- sample_valid  output  1  one-cycle pulse: sampled_bit updated this cycle.
- edge_cnt  output  PRESCALE_W  edge index within current bit, 0..P-1.
- bit_cnt  output  BIT_CNT_W  bit index within frame, start bit = 0.
- bit_done  output  1  one-cycle pulse at the first cycle of each new bit period.

Behaviour:
- Reset (RST=0 at CLK edge), all registered:
  - edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0, bit_done=0.
  - Sample regs s0/s1/s2=1, latched prescale P=8.
- Prescale latch:
  - Latched into P on any cycle with samp_en=0, so P is stable for the whole time samp_en=1.
  - Changes to prescale while samp_en=1 are ignored.
  - Illegal values (not 8/16/32) latch as 8.
- H = P/2.
- samp_en=0:
  - Next edge: edge_cnt=0, bit_cnt=0, sample_valid=0, bit_done=0.
  - sampled_bit and s0..s2 hold.
- samp_en=1, each cycle:
  - edge_cnt==P-1: edge_cnt→0, bit_cnt→bit_cnt+1 (saturates at all-ones), bit_done registered 1.
  - Otherwise edge_cnt→edge_cnt+1, bit_done→0.
  - edge_cnt==H-1 → s0<=RX_IN; edge_cnt==H → s1<=RX_IN; edge_cnt==H+1 → s2<=RX_IN.
  - edge_cnt==H+2 → sampled_bit<=maj(s0,s1,s2), sample_valid<=1.
  - All other cycles sample_valid<=0.
- Latency:
  - sample_valid and the new sampled_bit are visible in the cycle where edge_cnt==H+3 (P=8: edge 7; P=16: edge 11; P=32: edge 19).
  - Exactly one sample_valid per bit period.
- Majority: 1 if at least two of s0..s2 are 1. A single-sample glitch never changes the result.
- samp_en falling mid-bit: counters clear next edge. Any in-progress sample triple is discarded: no sample_valid, sampled_bit unchanged.
- Simultaneous samp_en=0 and edge_cnt==H+2: samp_en wins, no update.
- Reset mid-frame: reset wins over all; outputs return to reset values next edge.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro RX_SYNC_EN.
- Defined:
  - RX_IN passes through a 2-flop synchronizer (reset value 1) before sampling.
  - All sample points see RX_IN delayed by 2 CLK cycles. Counter timing is unchanged.
- Undefined: RX_IN sampled directly, no added latency.

Test Plan:
- Reset: hold RST=0 3 cycles with RX_IN=0, samp_en=1 → sampled_bit=1, edge_cnt=0, bit_cnt=0, sample_valid=0, bit_done=0.
- Clean bits: prescale=8, samp_en=1, RX_IN=0 for 8 cycles then 1 for 8 → sample_valid at edge 7 of each bit. sampled_bit=0 then 1. bit_done at edge 0 of bit 1. bit_cnt=1 after 8 cycles.
- Glitch rejection: prescale=16, RX_IN=1 except 0 only at edge 8 → sampled_bit=1. RX_IN=0 at edges 7 and 8 → sampled_bit=0.
- Prescale 32 plus mid-frame change: latch 32, change input to 8 while samp_en=1 → edge_cnt wraps at 31. sample_valid at edge 19. New value takes effect only after samp_en=0.
- Abort: samp_en=1 with prescale=8, drop samp_en at edge 5 → no sample_valid, sampled_bit holds, edge_cnt=0 and bit_cnt=0 next cycle.
- Saturation plus illegal prescale: prescale=12 latches 8. Run 20 bit periods → bit_cnt stops at 15. With RX_SYNC_EN defined, RX_IN edge appears at sample points 2 cycles later.
